note_field_scroller: RTL

Feeds the falling-note row RAM that the graphics stage renders from, driving that RAM's write port (`data`/`wraddress`/`wren`). The RAM is a circular buffer of `ROWS` note rows, each `ROW_W` bits wide. After reset it sweeps the RAM to zero. Every `FRAMES_PER_STEP` frames it then fetches the next chart row from the song ROM and writes it as the new top row, advancing a head pointer. The graphics stage uses that head pointer to read screen row k at RAM address (`head` + k) mod `ROWS`.

---
 rtl/note_field_scroller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/note_field_scroller.sv
`default_nettype none
// ============================================================================
// Module   : note_field_scroller
// Purpose  : Drives the falling-note row RAM write port. After reset it clears
//            the field, then writes one chart row per scroll step as the new top row.
// Revision : 1.0 - initial release
// ============================================================================

module note_field_scroller #(
  parameter int ROWS            = 20,
  parameter int ROW_W           = 128,
  parameter int CHART_AW        = 8,
  parameter int CHART_LEN       = 256,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                vgaclk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                restart,
  input  logic                frame_tick,
  output logic [CHART_AW-1:0] rom_addr,
  input  logic [ROW_W-1:0]    rom_q,
  output logic [4:0]          wraddress,
  output logic [ROW_W-1:0]    data,
  output logic                wren,
  output logic [4:0]          head,
  output logic                step_pulse,
  output logic                song_done
);

  localparam int c_PW = CHART_AW + 1;
  localparam int c_FW = $clog2(FRAMES_PER_STEP + 1);
  localparam int c_DW = $clog2(ROWS + 1);

  localparam logic [4:0]      c_LAST_ROW   = 5'(ROWS - 1);
  localparam logic [c_PW-1:0] c_LEN        = c_PW'(CHART_LEN);
  localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAMES_PER_STEP - 1);
  localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [4:0]        r_clr, w_clr;
  logic [4:0]        r_head, w_head;
  logic [c_PW-1:0]   r_ptr, w_ptr;
  logic [c_FW-1:0]   r_frame, w_frame;
  logic [c_DW-1:0]   r_drain, w_drain;
  logic              r_wren, w_wren;
  logic [4:0]        r_wraddr, w_wraddr;
  logic [ROW_W-1:0]  r_data, w_data;
  logic              r_step, w_step;
  logic              r_done, w_done;
  logic [4:0]        w_nh;
  logic              w_in_chart;

  assign w_nh       = (r_head == 5'd0) ? c_LAST_ROW : r_head - 5'd1;
  assign w_in_chart = (r_ptr < c_LEN);

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_CLEAR;
      r_clr    <= '0;
      r_head   <= '0;
      r_ptr    <= '0;
      r_frame  <= '0;
      r_drain  <= '0;
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_data   <= '0;
      r_step   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_clr    <= w_clr;
      r_head   <= w_head;
      r_ptr    <= w_ptr;
      r_frame  <= w_frame;
      r_drain  <= w_drain;
      r_wren   <= w_wren;
      r_wraddr <= w_wraddr;
      r_data   <= w_data;
      r_step   <= w_step;
      r_done   <= w_done;
    end
  end

  // Write-port registers are loaded on the edge that enters the state they belong to.
  always_comb begin
    w_state  = r_state;
    w_clr    = r_clr;
    w_head   = r_head;
    w_ptr    = r_ptr;
    w_frame  = r_frame;
    w_drain  = r_drain;
    w_wren   = 1'b0;
    w_wraddr = '0;
    w_data   = '0;
    w_step   = 1'b0;
    w_done   = r_done;

    if (restart) begin
      // The sweep starts right away with row 0.
      w_state  = (ROWS == 1) ? S_WAIT : S_CLEAR;
      w_clr    = 5'd1;
      w_head   = '0;
      w_ptr    = '0;
      w_frame  = '0;
      w_drain  = '0;
      w_done   = 1'b0;
      w_wren   = 1'b1;
      w_wraddr = '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          w_wren   = 1'b1;
          w_wraddr = r_clr;
          if (r_clr == c_LAST_ROW) begin
            w_clr   = '0;
            w_state = S_WAIT;
          end else begin
            w_clr = r_clr + 5'd1;
          end
        end
        S_WAIT: begin
          if (run && frame_tick) begin
            if (r_frame == c_FRAME_LAST) begin
              w_frame = '0;
              w_state = S_FETCH;
            end else begin
              w_frame = r_frame + c_FW'(1);
            end
          end
        end
        S_FETCH: begin
          w_state  = S_WRITE;
          w_wren   = 1'b1;
          w_wraddr = w_nh;
          w_data   = w_in_chart ? rom_q : '0;
          w_step   = 1'b1;
        end
        S_WRITE: begin
          w_head  = w_nh;
          w_state = S_WAIT;
          if (w_in_chart) begin
            w_ptr = r_ptr + c_PW'(1);
          end else begin
            w_drain = r_drain + c_DW'(1);
            if (r_drain == c_DRAIN_LAST) begin
              w_state = S_DONE;
              w_done  = 1'b1;
            end
          end
        end
        S_DONE: begin
          w_state = S_DONE;
        end
        default: begin
          w_state = S_CLEAR;
        end
      endcase
    end
  end

  assign rom_addr   = r_ptr[CHART_AW-1:0];
  assign wraddress  = r_wraddr;
  assign data       = r_data;
  assign wren       = r_wren;
  assign head       = r_head;
  assign step_pulse = r_step;
  assign song_done  = r_done;

endmodule

`default_nettype wire
